store_vector_writer: RTL and testbench

- Parametrised STORE engine for the execution unit; replaces the read-and-discard store path.
- Per command, fetches ceil(length/TILE_ELEMS) tiles from the vector buffer controller and serialises each tile into DRAM write beats of BEAT_BYTES bytes.
- Uses a valid/ready handshake with per-byte strobes, masks the partial tail beat, and pulses done after the last beat.

---
 rtl/store_vector_writer.sv | 209 ++++++++++++++++++++
 tb/tb_store_vector_writer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_vector_writer.sv
// STORE engine: reads tiles from the vector buffer controller and streams them to DRAM as strobed write beats.
// Optional STORE_CHECKSUM_EN adds a 32-bit byte-sum output of all strobed bytes per command.
module store_vector_writer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TILE_WIDTH = 256,
  parameter int unsigned TILE_ELEMS = TILE_WIDTH / DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = 24,
  parameter int unsigned BEAT_BYTES = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [4:0]                       src_buffer_id,
  input  logic [9:0]                       length,
  input  logic [ADDR_WIDTH-1:0]            addr,
  output logic                             busy,
  output logic                             done,
  output logic                             vec_read_enable,
  output logic [4:0]                       vec_read_buffer_id,
  input  logic [TILE_ELEMS*DATA_WIDTH-1:0] vec_read_tile,
  input  logic                             vec_read_valid,
  output logic                             dram_wr_valid,
  input  logic                             dram_wr_ready,
  output logic [ADDR_WIDTH-1:0]            dram_wr_addr,
  output logic [8*BEAT_BYTES-1:0]          dram_wr_data,
  output logic [BEAT_BYTES-1:0]            dram_wr_strb
`ifdef STORE_CHECKSUM_EN
  ,
  output logic [31:0]                      checksum
`endif
);

  localparam int unsigned TW  = TILE_ELEMS * DATA_WIDTH;
  localparam int unsigned BW  = 8 * BEAT_BYTES;
  localparam int unsigned BPT = TW / BW;
  localparam int unsigned EPB = BW / DATA_WIDTH;
  localparam int unsigned EB  = DATA_WIDTH / 8;
  localparam int unsigned BIW = (BPT > 1) ? $clog2(BPT) : 1;
  localparam int unsigned CW  = 11;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_REQ       = 3'd1;
  localparam logic [2:0] S_WAIT_TILE = 3'd2;
  localparam logic [2:0] S_WRITE     = 3'd3;
  localparam logic [2:0] S_FINISH    = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [4:0]            buf_q, buf_d;
  logic [CW-1:0]         len_q, len_d;
  logic [CW-1:0]         e_q, e_d, e_inc;
  logic [BIW-1:0]        b_q, b_d;
  logic [TW-1:0]         tile_q, tile_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BW-1:0]         wr_data_q, wr_data_d;
  logic [BEAT_BYTES-1:0] wr_strb_q, wr_strb_d;
  logic                  busy_q, done_q, rd_en_q, wr_valid_q;

  logic [TW-1:0]         sel_tile;
  logic [BIW-1:0]        sel_beat;
  logic [CW-1:0]         sel_base;
  logic [BW-1:0]         beat_raw;
  logic [BW-1:0]         pay_data;
  logic [BEAT_BYTES-1:0] pay_strb;

`ifdef STORE_CHECKSUM_EN
  logic [31:0] sum_q, sum_d, beat_sum;

  always_comb begin
    beat_sum = '0;
    for (int unsigned k = 0; k < BEAT_BYTES; k++) begin
      beat_sum = beat_sum + 32'(wr_data_q[8*k +: 8]);
    end
  end
`endif

  assign e_inc = e_q + CW'(EPB);

  // Payload of the next beat: beat 0 of an incoming tile, or the following beat of the held tile.
  always_comb begin
    if (state_q == S_WAIT_TILE) begin
      sel_tile = vec_read_tile;
      sel_beat = '0;
      sel_base = e_q;
    end else begin
      sel_tile = tile_q;
      sel_beat = b_q + BIW'(1);
      sel_base = e_inc;
    end
    beat_raw = BW'(sel_tile >> (int'(sel_beat) * BW));
    pay_data = '0;
    pay_strb = '0;
    for (int unsigned k = 0; k < BEAT_BYTES; k++) begin
      pay_strb[k] = (sel_base + CW'(k / EB)) < len_q;
      pay_data[8*k +: 8] = pay_strb[k] ? beat_raw[8*k +: 8] : 8'h00;
    end
  end

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    len_d     = len_q;
    e_d       = e_q;
    b_d       = b_q;
    tile_d    = tile_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    wr_strb_d = wr_strb_q;
`ifdef STORE_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          buf_d   = src_buffer_id;
          len_d   = {1'b0, length};
          addr_d  = addr;
          e_d     = '0;
          b_d     = '0;
`ifdef STORE_CHECKSUM_EN
          sum_d   = '0;
`endif
          state_d = (length == 10'd0) ? S_FINISH : S_REQ;
        end
      end
      S_REQ: state_d = S_WAIT_TILE;
      S_WAIT_TILE: begin
        if (vec_read_valid) begin
          tile_d    = vec_read_tile;
          b_d       = '0;
          wr_data_d = pay_data;
          wr_strb_d = pay_strb;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        if (dram_wr_ready) begin
          addr_d = addr_q + ADDR_WIDTH'(BEAT_BYTES);
          e_d    = e_inc;
`ifdef STORE_CHECKSUM_EN
          sum_d  = sum_q + beat_sum;
`endif
          if (e_inc >= len_q) begin
            state_d = S_FINISH;
          end else if (b_q == BIW'(BPT - 1)) begin
            state_d = S_REQ;
          end else begin
            b_d       = b_q + BIW'(1);
            wr_data_d = pay_data;
            wr_strb_d = pay_strb;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Control outputs are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      buf_q      <= '0;
      len_q      <= '0;
      e_q        <= '0;
      b_q        <= '0;
      tile_q     <= '0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_valid_q <= 1'b0;
`ifdef STORE_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      len_q      <= len_d;
      e_q        <= e_d;
      b_q        <= b_d;
      tile_q     <= tile_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      wr_strb_q  <= wr_strb_d;
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_FINISH);
      rd_en_q    <= (state_d == S_REQ);
      wr_valid_q <= (state_d == S_WRITE);
`ifdef STORE_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign vec_read_enable    = rd_en_q;
  assign vec_read_buffer_id = buf_q;
  assign dram_wr_valid      = wr_valid_q;
  assign dram_wr_addr       = addr_q;
  assign dram_wr_data       = wr_data_q;
  assign dram_wr_strb       = wr_strb_q;
`ifdef STORE_CHECKSUM_EN
  assign checksum           = sum_q;
`endif

endmodule

// File: tb/tb_store_vector_writer.sv
// Directed bench for store_vector_writer: reference beat list built from element indices, checked every cycle.
module tb_store_vector_writer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [4:0]   src_buffer_id;
  logic [9:0]   length;
  logic [23:0]  addr;
  logic         busy, done, vec_read_enable;
  logic [4:0]   vec_read_buffer_id;
  logic [255:0] vec_read_tile;
  logic         vec_read_valid;
  logic         dram_wr_valid;
  logic         dram_wr_ready;
  logic [23:0]  dram_wr_addr;
  logic [31:0]  dram_wr_data;
  logic [3:0]   dram_wr_strb;
`ifdef STORE_CHECKSUM_EN
  logic [31:0]  checksum;
`endif

  store_vector_writer dut (
    .clk(clk), .rst(rst), .start(start), .src_buffer_id(src_buffer_id),
    .length(length), .addr(addr), .busy(busy), .done(done),
    .vec_read_enable(vec_read_enable), .vec_read_buffer_id(vec_read_buffer_id),
    .vec_read_tile(vec_read_tile), .vec_read_valid(vec_read_valid),
    .dram_wr_valid(dram_wr_valid), .dram_wr_ready(dram_wr_ready),
    .dram_wr_addr(dram_wr_addr), .dram_wr_data(dram_wr_data),
    .dram_wr_strb(dram_wr_strb)
`ifdef STORE_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } beat_t;

  beat_t       expq[$];
  int          total = 0, bad = 0;
  int          cyc = 0;
  int          reads, xfers, dones, busy_cycles, valid_seen, done_cyc, tile_idx;
  int          bp = 0, ph = 0;
  logic [4:0]  exp_id;
  logic [31:0] exp_sum;
  logic [23:0] xa[16];
  logic [31:0] xd[16];
  logic [3:0]  xs[16];
  int          xcyc[16], pcyc[16];
  logic        prev_stall = 1'b0;
  logic [23:0] pa;
  logic [31:0] pd;
  logic [3:0]  ps;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: beat g carries elements 4g..4g+3, element e has value e mod 256, enabled iff e < len.
  task automatic build(input int len, input logic [23:0] a);
    beat_t b;
    expq.delete();
    exp_sum = 0;
    for (int g = 0; g < (len + 3) / 4; g++) begin
      b.a = a + 24'(4 * g);
      b.d = '0;
      b.s = '0;
      for (int k = 0; k < 4; k++) begin
        int e;
        e = 4 * g + k;
        if (e < len) begin
          b.s = b.s | (4'b0001 << k);
          b.d = b.d | (32'(e & 255) << (8 * k));
          exp_sum = exp_sum + 32'(e & 255);
        end
      end
      expq.push_back(b);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Ready pattern: always high, or 1,0,0 repeating.
  initial begin
    dram_wr_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp != 0) begin
        dram_wr_ready = (ph == 0);
        ph = (ph + 1) % 3;
      end else begin
        dram_wr_ready = 1'b1;
      end
    end
  end

  // Tile source: answers each read request one cycle later with tile t, element i = 32t+i.
  initial begin
    logic [255:0] t;
    vec_read_valid = 1'b0;
    vec_read_tile  = '0;
    forever begin
      @(negedge clk);
      if (vec_read_enable && !rst) begin
        reads++;
        chk("rd_buf_id", 64'(vec_read_buffer_id), 64'(exp_id));
        @(posedge clk); #1;
        t = '0;
        for (int i = 0; i < 32; i++) t = t | (256'((32 * tile_idx + i) & 255) << (8 * i));
        tile_idx++;
        vec_read_tile  = t;
        vec_read_valid = 1'b1;
        @(posedge clk); #1;
        vec_read_valid = 1'b0;
        vec_read_tile  = '1;
      end
    end
  end

  // Compare process: holds under backpressure, beat contents, done/busy bookkeeping.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(dram_wr_valid), 64'(1));
        chk("hold_addr", 64'(dram_wr_addr), 64'(pa));
        chk("hold_data", 64'(dram_wr_data), 64'(pd));
        chk("hold_strb", 64'(dram_wr_strb), 64'(ps));
      end
      if (dram_wr_valid) begin
        valid_seen++;
        if (!prev_stall && xfers < 16) pcyc[xfers] = cyc;
      end
      if (dram_wr_valid && dram_wr_ready) begin
        if (expq.size() == 0) begin
          chk("extra_beat", 64'(1), 64'(0));
        end else begin
          beat_t e;
          e = expq.pop_front();
          chk("beat_addr", 64'(dram_wr_addr), 64'(e.a));
          chk("beat_data", 64'(dram_wr_data), 64'(e.d));
          chk("beat_strb", 64'(dram_wr_strb), 64'(e.s));
        end
        if (xfers < 16) begin
          xa[xfers] = dram_wr_addr;
          xd[xfers] = dram_wr_data;
          xs[xfers] = dram_wr_strb;
          xcyc[xfers] = cyc;
        end
        xfers++;
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
      if (busy) busy_cycles++;
      prev_stall <= dram_wr_valid && !dram_wr_ready;
      pa <= dram_wr_addr;
      pd <= dram_wr_data;
      ps <= dram_wr_strb;
    end
  end

  task automatic clear_stats(input logic [4:0] id);
    reads = 0; xfers = 0; dones = 0; busy_cycles = 0; valid_seen = 0;
    done_cyc = -1; tile_idx = 0; exp_id = id;
  endtask

  task automatic run_cmd(input int len, input logic [23:0] a, input logic [4:0] id, input bit stray);
    build(len, a);
    clear_stats(id);
    @(posedge clk); #1;
    start = 1'b1; src_buffer_id = id; length = 10'(len); addr = a;
    @(posedge clk); #1;
    start = 1'b0; src_buffer_id = 5'h1F; length = 10'h3FF; addr = 24'hABCDEF;
    if (stray) begin
      repeat (3) @(posedge clk);
      #1; start = 1'b1; length = 10'd0;
      @(posedge clk); #1; start = 1'b0;
    end
    for (int i = 0; i < 3000 && dones == 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk("done_count", 64'(dones), 64'(1));
    chk("beats_left", 64'(expq.size()), 64'(0));
    chk("beat_count", 64'((len + 3) / 4), 64'(xfers));
    chk("idle_after", 64'(busy), 64'(0));
`ifdef STORE_CHECKSUM_EN
    chk("checksum", 64'(checksum), 64'(exp_sum));
`endif
  endtask

  task automatic check_zero_outputs(input string nm);
    chk({nm, "_busy"}, 64'(busy), 64'(0));
    chk({nm, "_done"}, 64'(done), 64'(0));
    chk({nm, "_rd_en"}, 64'(vec_read_enable), 64'(0));
    chk({nm, "_rd_id"}, 64'(vec_read_buffer_id), 64'(0));
    chk({nm, "_valid"}, 64'(dram_wr_valid), 64'(0));
    chk({nm, "_addr"}, 64'(dram_wr_addr), 64'(0));
    chk({nm, "_data"}, 64'(dram_wr_data), 64'(0));
    chk({nm, "_strb"}, 64'(dram_wr_strb), 64'(0));
`ifdef STORE_CHECKSUM_EN
    chk({nm, "_checksum"}, 64'(checksum), 64'(0));
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; src_buffer_id = '0; length = '0; addr = '0;
    clear_stats(5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #1; rst = 1'b0;

    // Single full tile
    run_cmd(32, 24'h000100, 5'd3, 1'b0);
    chk("t1_reads", 64'(reads), 64'(1));
    chk("t1_addr0", 64'(xa[0]), 64'(24'h000100));
    chk("t1_addr7", 64'(xa[7]), 64'(24'h00011C));
    chk("t1_data0", 64'(xd[0]), 64'(32'h03020100));
    chk("t1_strb7", 64'(xs[7]), 64'(4'hF));
    chk("t1_done_lat", 64'(done_cyc), 64'(xcyc[7] + 1));
`ifdef STORE_CHECKSUM_EN
    chk("t1_sum_lit", 64'(checksum), 64'(496));
`endif

    // Two tiles with partial tail beat
    run_cmd(37, 24'h000100, 5'd7, 1'b0);
    chk("t2_reads", 64'(reads), 64'(2));
    chk("t2_xfers", 64'(xfers), 64'(10));
    chk("t2_last_addr", 64'(xa[9]), 64'(24'h000124));
    chk("t2_last_strb", 64'(xs[9]), 64'(4'h1));
    chk("t2_last_data", 64'(xd[9]), 64'(32'h00000024));
    chk("t2_data8", 64'(xd[8]), 64'(32'h23222120));
    chk("t2_bubble", 64'(pcyc[8]), 64'(xcyc[7] + 3));
    chk("t2_done_lat", 64'(done_cyc), 64'(xcyc[9] + 1));

    // Backpressure 1,0,0 with a stray start while busy
    bp = 1; ph = 0;
    run_cmd(32, 24'h000100, 5'd3, 1'b1);
    bp = 0;
    chk("t3_reads", 64'(reads), 64'(1));
    chk("t3_xfers", 64'(xfers), 64'(8));
    chk("t3_data0", 64'(xd[0]), 64'(32'h03020100));
    chk("t3_done_lat", 64'(done_cyc), 64'(xcyc[7] + 1));

    // Zero length
    run_cmd(0, 24'h000200, 5'd1, 1'b0);
    chk("t4_reads", 64'(reads), 64'(0));
    chk("t4_valid_seen", 64'(valid_seen), 64'(0));
    chk("t4_busy_cycles", 64'(busy_cycles), 64'(1));
`ifdef STORE_CHECKSUM_EN
    chk("t4_sum_lit", 64'(checksum), 64'(0));
`endif

    // Address wrap
    run_cmd(16, 24'hFFFFF8, 5'd9, 1'b0);
    chk("t5_addr0", 64'(xa[0]), 64'(24'hFFFFF8));
    chk("t5_addr1", 64'(xa[1]), 64'(24'hFFFFFC));
    chk("t5_addr2", 64'(xa[2]), 64'(24'h000000));
    chk("t5_addr3", 64'(xa[3]), 64'(24'h000004));

    // Reset during the 3rd beat aborts the command
    build(32, 24'h000100);
    clear_stats(5'd4);
    @(posedge clk); #1;
    start = 1'b1; src_buffer_id = 5'd4; length = 10'd32; addr = 24'h000100;
    @(posedge clk); #1; start = 1'b0;
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
        @(posedge clk); #1;
        if (dram_wr_valid && xfers == 2) hit = 1'b1;
      end
      chk("t6_third_beat", 64'(hit), 64'(1));
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_zero_outputs("t6_abort");
    @(posedge clk); #1; rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_no_done", 64'(dones), 64'(0));
    chk("t6_no_more_beats", 64'(xfers), 64'(2));
    chk("t6_no_valid", 64'(dram_wr_valid), 64'(0));

    run_cmd(4, 24'h000040, 5'd2, 1'b0);
    chk("t7_xfers", 64'(xfers), 64'(1));
    chk("t7_addr", 64'(xa[0]), 64'(24'h000040));
    chk("t7_strb", 64'(xs[0]), 64'(4'hF));
    chk("t7_data", 64'(xd[0]), 64'(32'h03020100));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
